addr_gen_ctrl: RTL and testbench
================================

Name: addr_gen_ctrl

Overview:
- Parametrised next-generation affine address generator for memory-tile (lake) ports: nested loop counters over up to MAX_DIM dimensions produce `addr = start + sum(counter[i]*stride[i])`.
- Adds what the fixed 6-dim generator lacks:
  - configuration latched at start;
  - a valid/ready output handshake;
  - single-pass vs repeat mode;
  - a registered done pulse and a busy flag.
- Sits between the tile config registers and the SRAM/aggregation port it addresses.

Parameters:
- MAX_DIM, 6, maximum number of loop dimensions (1..16)
- AW, 16, address / start / stride width in bits
- CW, 16, loop-range and counter width in bits
- DIM_W, $clog2(MAX_DIM+1), width of dimensionality input

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- clk_en  in  1  global clock enable; when low all state holds
- flush  in  1  synchronous abort to IDLE (qualified by clk_en)
- start  in  1  begin a pass; sampled in IDLE only
- repeat_en  in  1  1 = loop forever, 0 = single pass; latched at start
- dimensionality  in  DIM_W  active dims; latched at start
- ranges  in  MAX_DIM*CW  per-dim iteration count; latched at start
- strides  in  MAX_DIM*AW  per-dim address increment; latched at start
- starting_addr  in  AW  base address; latched at start
- addr_ready  in  1  consumer accepts addr_out this cycle
- addr_out  out  AW  current address
- addr_valid  out  1  addr_out is valid
- busy  out  1  state is RUN
- done  out  1  one-cycle pulse after the final transfer of a single pass

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE;
  - all counters, loc accumulators and latched config = 0;
  - addr_valid = 0, busy = 0, done = 0, addr_out = 0.
- clk_en low: no state, counter or output register changes. done holds its value.
- Configuration latch:
  - dimensionality is clamped to MAX_DIM.
  - A range value of 0 is treated as 1.
- States: IDLE, RUN.
- IDLE:
  - addr_valid = 0.
  - On clk_en & start: latch config, zero all counters/locs, go to RUN next cycle.
- RUN:
  - addr_valid = 1.
  - addr_out = start_l + sum of loc[i] over i < dim_l, modulo 2^AW. This is combinational from registers, so the first address is valid the cycle after start is sampled.
- Transfer: addr_valid & addr_ready & clk_en. On a transfer, advance the dimensions:
  - upd[0] = 1; upd[i] = upd[i-1] & (cnt[i-1] == range_l[i-1]-1).
  - For each i < dim_l with upd[i]:
    - if cnt[i] == range_l[i]-1, then cnt[i] = 0 and loc[i] = 0;
    - else cnt[i] += 1 and loc[i] += stride_l[i] (AW-bit wrap).
  - last = upd[dim_l]. With dim_l = 0, last = 1 and the only address is starting_addr.
- On a transfer with last:
  - repeat_en_l = 1: counters wrap to 0, stay in RUN, no done.
  - repeat_en_l = 0: go to IDLE; done = 1 for exactly the next cycle.
- No transfer: addr_out and all counters hold. addr_valid stays high; do not drop valid without a transfer.
- start while in RUN is ignored. Config inputs may change freely during RUN; the latched copies are used.
- flush & clk_en:
  - highest priority over start and over a transfer in the same cycle;
  - state = IDLE, counters/locs = 0, addr_valid = 0 next cycle, done = 0 (no pulse).
- done is cleared on the next clk_en cycle that does not itself generate a done.
- Dimensions i >= dim_l never change and contribute 0 to the sum.

Test Plan:
- All scenarios use AW = CW = 16 and MAX_DIM = 6 unless stated.
- 2-D single pass: dim=2, ranges={3,2}, strides={1,10}, start=100, ready held 1 -> addr_out sequence 100,101,102,110,111,112. addr_valid for 6 cycles, then done pulses 1 cycle, busy drops.
- Backpressure: same config, ready toggles 1,0,0,1,... -> each address is held stable with valid high until accepted. The sequence is unchanged and no address is skipped or duplicated.
- Repeat mode: dim=1, range=4, stride=2, start=0, repeat_en=1 -> 0,2,4,6,0,2,... with no done pulse. flush mid-stream -> valid low next cycle, IDLE, done stays 0.
- Edge config:
  - dim=0, start=0x55 -> one address 0x55 then done;
  - range=0 on dim 0 behaves as 1;
  - stride=0xFFFF, start=1, range=3 -> addresses 1, 0, 0xFFFF (modular).
- Latching and priority:
  - change ranges/strides during RUN -> output unaffected;
  - start during RUN ignored;
  - start and flush in the same cycle in IDLE -> stays IDLE;
  - clk_en low for 5 cycles mid-run -> full freeze.
- Reset mid-operation: assert rst_n low asynchronously during RUN -> addr_valid, busy, done and addr_out go 0 immediately. A start after release restarts from starting_addr.

Source files
------------

// File: rtl/addr_gen_ctrl_if.sv
// Address output handshake between the affine address generator and the
// SRAM/aggregation port it feeds.
interface addr_gen_ctrl_if #(
    parameter int AW = 16
);
    logic [AW-1:0] addr_out;
    logic          addr_valid;
    logic          addr_ready;

    modport master (
        output addr_out,
        output addr_valid,
        input  addr_ready
    );

    modport slave (
        input  addr_out,
        input  addr_valid,
        output addr_ready
    );
endinterface

// File: rtl/addr_gen_ctrl.sv
// Affine nested-loop address generator: addr = start + sum(cnt[i]*stride[i]),
// with configuration latched at start, valid/ready output and repeat mode.
module addr_gen_ctrl #(
    parameter int MAX_DIM = 6,
    parameter int AW      = 16,
    parameter int CW      = 16,
    parameter int DIM_W   = $clog2(MAX_DIM + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en,
    input  logic                  flush,
    input  logic                  start,
    input  logic                  repeat_en,
    input  logic [DIM_W-1:0]      dimensionality,
    input  logic [MAX_DIM*CW-1:0] ranges,
    input  logic [MAX_DIM*AW-1:0] strides,
    input  logic [AW-1:0]         starting_addr,
    addr_gen_ctrl_if.master       addr_if,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t                      state_q,  state_d;
    logic [MAX_DIM-1:0][CW-1:0]  cnt_q,    cnt_d;
    logic [MAX_DIM-1:0][AW-1:0]  loc_q,    loc_d;
    logic [MAX_DIM-1:0][CW-1:0]  range_q,  range_d;
    logic [MAX_DIM-1:0][AW-1:0]  stride_q, stride_d;
    logic [AW-1:0]               base_q,   base_d;
    logic [DIM_W-1:0]            dim_q,    dim_d;
    logic                        rep_q,    rep_d;
    logic                        done_q,   done_d;

    logic [MAX_DIM:0]            upd;
    logic                        last;
    logic                        xfer;
    logic [AW-1:0]               addr_sum;
    logic [CW-1:0]               range_in;

    // Carry chain: dimension i advances when every lower dimension wraps.
    always_comb begin
        upd    = '0;
        upd[0] = 1'b1;
        for (int i = 1; i <= MAX_DIM; i++) begin
            upd[i] = upd[i-1] & (cnt_q[i-1] == range_q[i-1] - CW'(1));
        end
        last = upd[dim_q];
        xfer = (state_q == RUN) & addr_if.addr_ready & clk_en;
    end

    always_comb begin
        addr_sum = base_q;
        for (int i = 0; i < MAX_DIM; i++) begin
            if (DIM_W'(i) < dim_q) begin
                addr_sum = addr_sum + loc_q[i];
            end
        end
    end

    assign addr_if.addr_out   = addr_sum;
    assign addr_if.addr_valid = (state_q == RUN);
    assign busy               = (state_q == RUN);
    assign done               = done_q;

    // With clk_en low every _d equals its _q, so the whole block freezes.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        loc_d    = loc_q;
        range_d  = range_q;
        stride_d = stride_q;
        base_d   = base_q;
        dim_d    = dim_q;
        rep_d    = rep_q;
        done_d   = done_q;
        range_in = '0;

        if (clk_en) begin
            done_d = 1'b0;
            if (flush) begin
                state_d = IDLE;
                cnt_d   = '0;
                loc_d   = '0;
            end else if (state_q == IDLE) begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    loc_d   = '0;
                    base_d  = starting_addr;
                    rep_d   = repeat_en;
                    dim_d   = (dimensionality > DIM_W'(MAX_DIM)) ? DIM_W'(MAX_DIM)
                                                                 : dimensionality;
                    for (int i = 0; i < MAX_DIM; i++) begin
                        range_in    = ranges[i*CW +: CW];
                        range_d[i]  = (range_in == '0) ? CW'(1) : range_in;
                        stride_d[i] = strides[i*AW +: AW];
                    end
                end
            end else if (xfer) begin
                for (int i = 0; i < MAX_DIM; i++) begin
                    if ((DIM_W'(i) < dim_q) && upd[i]) begin
                        if (cnt_q[i] == range_q[i] - CW'(1)) begin
                            cnt_d[i] = '0;
                            loc_d[i] = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CW'(1);
                            loc_d[i] = loc_q[i] + stride_q[i];
                        end
                    end
                end
                if (last && !rep_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            loc_q    <= '0;
            range_q  <= '0;
            stride_q <= '0;
            base_q   <= '0;
            dim_q    <= '0;
            rep_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            loc_q    <= loc_d;
            range_q  <= range_d;
            stride_q <= stride_d;
            base_q   <= base_d;
            dim_q    <= dim_d;
            rep_q    <= rep_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_addr_gen_ctrl.sv
// Directed testbench for addr_gen_ctrl: hand-computed address sequences,
// backpressure, repeat/flush, edge configurations, freeze and async reset.
module tb_addr_gen_ctrl;

    localparam int MAX_DIM = 6;
    localparam int AW      = 16;
    localparam int CW      = 16;
    localparam int DIM_W   = 3;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  clk_en;
    logic                  flush;
    logic                  start;
    logic                  repeat_en;
    logic [DIM_W-1:0]      dimensionality;
    logic [MAX_DIM*CW-1:0] ranges;
    logic [MAX_DIM*AW-1:0] strides;
    logic [AW-1:0]         starting_addr;
    logic                  busy;
    logic                  done;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp2d [6] = '{16'd100, 16'd101, 16'd102, 16'd110, 16'd111, 16'd112};
    logic [15:0] exprep [4] = '{16'd0, 16'd2, 16'd4, 16'd6};

    addr_gen_ctrl_if #(.AW(AW)) agi ();

    addr_gen_ctrl #(
        .MAX_DIM (MAX_DIM),
        .AW      (AW),
        .CW      (CW),
        .DIM_W   (DIM_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clk_en         (clk_en),
        .flush          (flush),
        .start          (start),
        .repeat_en      (repeat_en),
        .dimensionality (dimensionality),
        .ranges         (ranges),
        .strides        (strides),
        .starting_addr  (starting_addr),
        .addr_if        (agi),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [DIM_W-1:0] dim, input logic [15:0] r0,
                                 input logic [15:0] r1, input logic [15:0] s0,
                                 input logic [15:0] s1, input logic [15:0] base,
                                 input logic rep);
        dimensionality  = dim;
        ranges          = '0;
        ranges[15:0]    = r0;
        ranges[31:16]   = r1;
        strides         = '0;
        strides[15:0]   = s0;
        strides[31:16]  = s1;
        starting_addr   = base;
        repeat_en       = rep;
    endtask

    task automatic stepCycle();
        @(negedge clk);
    endtask

    task automatic startPass();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic expectAddr(input string tag, input logic [15:0] a);
        checkOutput({tag, "_valid"}, {31'd0, agi.addr_valid}, 32'd1);
        checkOutput(tag, {16'd0, agi.addr_out}, {16'd0, a});
    endtask

    task automatic expectIdleDone(input string tag, input logic d);
        checkOutput({tag, "_valid"}, {31'd0, agi.addr_valid}, 32'd0);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_done"}, {31'd0, done}, {31'd0, d});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int idx;
        int cyc;
        logic rdy;

        rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0; start = 1'b0;
        agi.addr_ready = 1'b0;
        applyStimulus(3'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0);
        stepCycle();
        stepCycle();
        expectIdleDone("reset", 1'b0);
        checkOutput("reset_addr", {16'd0, agi.addr_out}, 32'd0);
        rst_n = 1'b1;
        stepCycle();

        $display("[TB] 2-D single pass");
        applyStimulus(3'd2, 16'd3, 16'd2, 16'd1, 16'd10, 16'd100, 1'b0);
        agi.addr_ready = 1'b1;
        startPass();
        for (int k = 0; k < 6; k++) begin
            expectAddr($sformatf("pass2d_%0d", k), exp2d[k]);
            checkOutput("pass2d_busy", {31'd0, busy}, 32'd1);
            stepCycle();
        end
        expectIdleDone("pass2d_end", 1'b1);
        stepCycle();
        checkOutput("pass2d_done_clear", {31'd0, done}, 32'd0);

        $display("[TB] backpressure");
        agi.addr_ready = 1'b0;
        startPass();
        idx = 0;
        cyc = 0;
        while (idx < 6 && cyc < 40) begin
            expectAddr($sformatf("bp_%0d", idx), exp2d[idx]);
            rdy = (cyc % 3 == 0);
            agi.addr_ready = rdy;
            stepCycle();
            if (rdy) idx++;
            cyc++;
        end
        checkOutput("bp_count", idx, 32'd6);
        expectIdleDone("bp_end", 1'b1);

        $display("[TB] repeat mode and flush");
        applyStimulus(3'd1, 16'd4, 16'd0, 16'd2, 16'd0, 16'd0, 1'b1);
        agi.addr_ready = 1'b1;
        startPass();
        for (int k = 0; k < 10; k++) begin
            expectAddr($sformatf("rep_%0d", k), exprep[k % 4]);
            checkOutput("rep_no_done", {31'd0, done}, 32'd0);
            stepCycle();
        end
        flush = 1'b1;
        stepCycle();
        flush = 1'b0;
        expectIdleDone("flush", 1'b0);
        stepCycle();
        expectIdleDone("flush_after", 1'b0);

        $display("[TB] edge configurations");
        applyStimulus(3'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'h0055, 1'b0);
        startPass();
        expectAddr("dim0", 16'h0055);
        stepCycle();
        expectIdleDone("dim0_end", 1'b1);

        applyStimulus(3'd1, 16'd0, 16'd0, 16'd5, 16'd0, 16'd7, 1'b0);
        startPass();
        expectAddr("range0", 16'd7);
        stepCycle();
        expectIdleDone("range0_end", 1'b1);

        applyStimulus(3'd1, 16'd3, 16'd0, 16'hFFFF, 16'd0, 16'd1, 1'b0);
        startPass();
        expectAddr("wrap_0", 16'd1);
        stepCycle();
        expectAddr("wrap_1", 16'd0);
        stepCycle();
        expectAddr("wrap_2", 16'hFFFF);
        stepCycle();
        expectIdleDone("wrap_end", 1'b1);

        $display("[TB] latching and start during run");
        applyStimulus(3'd2, 16'd3, 16'd2, 16'd1, 16'd10, 16'd100, 1'b0);
        startPass();
        applyStimulus(3'd5, 16'd1, 16'd1, 16'h3333, 16'h3333, 16'h9999, 1'b1);
        start = 1'b1;
        for (int k = 0; k < 6; k++) begin
            expectAddr($sformatf("latch_%0d", k), exp2d[k]);
            if (k == 1) start = 1'b0;
            stepCycle();
        end
        expectIdleDone("latch_end", 1'b1);

        start = 1'b1;
        flush = 1'b1;
        stepCycle();
        start = 1'b0;
        flush = 1'b0;
        expectIdleDone("start_flush", 1'b0);

        $display("[TB] clock enable freeze");
        applyStimulus(3'd2, 16'd3, 16'd2, 16'd1, 16'd10, 16'd100, 1'b0);
        startPass();
        stepCycle();
        stepCycle();
        clk_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            stepCycle();
            expectAddr($sformatf("freeze_%0d", k), 16'd102);
        end
        clk_en = 1'b1;
        for (int k = 2; k < 6; k++) begin
            expectAddr($sformatf("thaw_%0d", k), exp2d[k]);
            stepCycle();
        end
        expectIdleDone("thaw_end", 1'b1);
        clk_en = 1'b0;
        stepCycle();
        stepCycle();
        checkOutput("freeze_done_hold", {31'd0, done}, 32'd1);
        clk_en = 1'b1;
        stepCycle();
        checkOutput("freeze_done_clear", {31'd0, done}, 32'd0);

        $display("[TB] async reset mid-run");
        startPass();
        expectAddr("rst_pre_0", 16'd100);
        stepCycle();
        expectAddr("rst_pre_1", 16'd101);
        #2 rst_n = 1'b0;
        #1;
        expectIdleDone("rst_mid", 1'b0);
        checkOutput("rst_mid_addr", {16'd0, agi.addr_out}, 32'd0);
        stepCycle();
        rst_n = 1'b1;
        stepCycle();
        startPass();
        expectAddr("rst_restart_0", 16'd100);
        stepCycle();
        expectAddr("rst_restart_1", 16'd101);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
